// File: rtl/eda_task_fifo_param.sv
// Parameterised synchronous FIFO with occupancy flags and overflow/underflow pulses.
// Optional first-word-fall-through output selected by defining FIFO_FWFT_EN.
module eda_task_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     SYSCLK,
    input  logic                     RST,
    input  logic                     WR_EN,
    input  logic                     RD_EN,
    input  logic [WIDTH-1:0]         FIFO_IN,
    output logic [WIDTH-1:0]         FIFO_OUT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     ALMOST_FULL,
    output logic                     ALMOST_EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_rd_acc;
    logic             w_wr_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == C_DEPTH);
    assign w_rd_acc = RD_EN && !w_empty;
    // A full FIFO still takes a write when the same edge frees a slot.
    assign w_wr_acc = WR_EN && (!w_full || w_rd_acc);

    always_ff @(posedge SYSCLK) begin
        if (w_wr_acc && !RST) begin
            r_mem[r_wr_ptr] <= FIFO_IN;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= WR_EN && !w_wr_acc;
            r_underflow <= RD_EN && w_empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented combinationally; zero while nothing is stored.
    assign FIFO_OUT = w_empty ? '0 : r_mem[r_rd_ptr];
`else
    logic [WIDTH-1:0] r_dout;

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= r_mem[r_rd_ptr];
        end
    end

    assign FIFO_OUT = r_dout;
`endif

    assign EMPTY        = w_empty;
    assign FULL         = w_full;
    assign ALMOST_FULL  = (r_count >= C_AF);
    assign ALMOST_EMPTY = (r_count <= C_AE);
    assign COUNT        = r_count;
    assign OVERFLOW     = r_overflow;
    assign UNDERFLOW    = r_underflow;

endmodule

// File: tb/tb_eda_task_fifo_param.sv
// Self-checking bench for eda_task_fifo_param (WIDTH=8, DEPTH=4, AF=3, AE=1):
// directed table, wrap sequence and randomized traffic against a queue model.
module tb_eda_task_fifo_param;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic         SYSCLK = 1'b0;
    logic         RST    = 1'b1;
    logic         WR_EN  = 1'b0;
    logic         RD_EN  = 1'b0;
    logic [W-1:0] FIFO_IN = '0;
    logic [W-1:0] FIFO_OUT;
    logic         EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY;
    logic [2:0]   COUNT;
    logic         OVERFLOW, UNDERFLOW;

    int tests  = 0;
    int failed = 0;

    eda_task_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .SYSCLK(SYSCLK), .RST(RST), .WR_EN(WR_EN), .RD_EN(RD_EN),
        .FIFO_IN(FIFO_IN), .FIFO_OUT(FIFO_OUT), .EMPTY(EMPTY), .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 SYSCLK = ~SYSCLK;

    // Reference model: plain queue of stored words.
    logic [W-1:0] q[$];
    logic [W-1:0] m_out;
    logic         m_ovf, m_unf;

    typedef struct {
        logic         rst, wr, rd;
        logic [W-1:0] din;
        int           cnt;
        logic [W-1:0] out;
        logic         ovf, unf;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic wr, input logic rd, input logic [W-1:0] din);
        bit ra, wa;
        logic [W-1:0] v;
        if (rst) begin
            q.delete();
            m_out = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            ra = rd && (q.size() > 0);
            wa = wr && ((q.size() < D) || ra);
            m_unf = rd && (q.size() == 0);
            m_ovf = wr && !wa;
            if (ra) begin
                v = q.pop_front();
`ifndef FIFO_FWFT_EN
                m_out = v;
`endif
            end
            if (wa) q.push_back(din);
        end
`ifdef FIFO_FWFT_EN
        m_out = (q.size() > 0) ? q[0] : '0;
`endif
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        chk("count",        32'(COUNT),        32'(n));
        chk("empty",        32'(EMPTY),        32'(n == 0));
        chk("full",         32'(FULL),         32'(n == D));
        chk("almost_full",  32'(ALMOST_FULL),  32'(n >= AF));
        chk("almost_empty", 32'(ALMOST_EMPTY), 32'(n <= AE));
        chk("overflow",     32'(OVERFLOW),     32'(m_ovf));
        chk("underflow",    32'(UNDERFLOW),    32'(m_unf));
        chk("fifo_out",     32'(FIFO_OUT),     32'(m_out));
    endtask

    task automatic step(input logic rst, input logic wr, input logic rd, input logic [W-1:0] din);
        RST = rst; WR_EN = wr; RD_EN = rd; FIFO_IN = din;
        @(posedge SYSCLK);
        model_step(rst, wr, rd, din);
        #1;
        check_model();
    endtask

    task automatic add(input logic rst, input logic wr, input logic rd, input logic [W-1:0] din,
                       input int cnt, input logic [W-1:0] out, input logic ovf, input logic unf);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.din = din;
        v.cnt = cnt; v.out = out; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    initial begin
        // rst wr rd din | count out(standard mode) ovf unf
        add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h01, 1, 8'h00, 0, 0);
        add(0, 1, 0, 8'h02, 2, 8'h00, 0, 0);
        add(0, 1, 0, 8'h03, 3, 8'h00, 0, 0);
        add(0, 0, 1, 8'h00, 2, 8'h01, 0, 0);
        add(0, 0, 1, 8'h00, 1, 8'h02, 0, 0);
        add(0, 0, 1, 8'h00, 0, 8'h03, 0, 0);
        add(0, 0, 1, 8'h00, 0, 8'h03, 0, 1);
        add(0, 0, 0, 8'h00, 0, 8'h03, 0, 0);
        add(0, 1, 0, 8'h10, 1, 8'h03, 0, 0);
        add(0, 1, 0, 8'h11, 2, 8'h03, 0, 0);
        add(0, 1, 0, 8'h12, 3, 8'h03, 0, 0);
        add(0, 1, 0, 8'h13, 4, 8'h03, 0, 0);
        add(0, 1, 0, 8'h14, 4, 8'h03, 1, 0);
        add(0, 0, 0, 8'h00, 4, 8'h03, 0, 0);
        add(0, 1, 1, 8'hAA, 4, 8'h10, 0, 0);
        add(0, 0, 1, 8'h00, 3, 8'h11, 0, 0);
        add(0, 0, 1, 8'h00, 2, 8'h12, 0, 0);
        add(0, 0, 1, 8'h00, 1, 8'h13, 0, 0);
        add(0, 0, 1, 8'h00, 0, 8'hAA, 0, 0);
        add(0, 1, 0, 8'h55, 1, 8'hAA, 0, 0);
        add(0, 1, 0, 8'h56, 2, 8'hAA, 0, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h55, 1, 8'h00, 0, 0);
        add(0, 0, 1, 8'h00, 0, 8'h55, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk($sformatf("vec%0d_count", i), 32'(COUNT),     32'(vecs[i].cnt));
            chk($sformatf("vec%0d_ovf", i),   32'(OVERFLOW),  32'(vecs[i].ovf));
            chk($sformatf("vec%0d_unf", i),   32'(UNDERFLOW), 32'(vecs[i].unf));
`ifndef FIFO_FWFT_EN
            chk($sformatf("vec%0d_out", i),   32'(FIFO_OUT),  32'(vecs[i].out));
`endif
        end

        // Ten write/read pairs: pointers wrap twice, data must stay in order.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, W'(8'h20 + i));
`ifdef FIFO_FWFT_EN
            chk($sformatf("wrap%0d_fwft_out", i), 32'(FIFO_OUT), 32'(8'h20 + i));
`endif
            step(0, 0, 1, 8'h00);
`ifndef FIFO_FWFT_EN
            chk($sformatf("wrap%0d_out", i), 32'(FIFO_OUT), 32'(8'h20 + i));
`endif
        end

        // Held full, then concurrent read/write for several cycles.
        for (int i = 0; i < 4; i++) step(0, 1, 0, W'(8'h60 + i));
        for (int i = 0; i < 6; i++) step(0, 1, 1, W'(8'h70 + i));
        chk("full_rw_count", 32'(COUNT), 32'(D));

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            logic r, w, rd;
            r  = ($urandom_range(0, 49) == 0);
            w  = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 50);
            step(r, w, rd, W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
